fsm_loop_datapath: RTL and testbench
====================================

Name: fsm_loop_datapath

Overview:
Datapath partner of the seven-state one-hot loop controller `fsm`. It consumes the controller's s0..s6 state strobes and returns the loop-continue branch condition B_ctrl_in0. Per loop iteration it reads one word from a synchronous memory (1-cycle read latency), multiplies it by a coefficient and accumulates the product. The final dot-product-style result is presented to downstream logic with a one-cycle valid pulse.

Parameters:
DATA_W, 16, memory word width (unsigned)
ADDR_W, 8, memory address width
LEN_W, 8, loop trip-count width
ACC_W, 40, accumulator/result width; must be >= 2*DATA_W

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  same start the controller sees; sampled only while s0_ctrl_in=1
len_in  in  LEN_W  trip count, latched on accepted start
base_in  in  ADDR_W  base address, latched on accepted start
coef_in  in  DATA_W  multiplier coefficient, latched on accepted start
s0_ctrl_in..s6_ctrl_in  in  1 each  one-hot state strobes from controller
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  read address
mem_rdata  in  DATA_W  read data, valid the cycle after mem_rd_en
B_ctrl_out0  out  1  loop-continue condition, wired to controller B_ctrl_in0
result  out  ACC_W  last committed accumulator value
result_valid  out  1  one-cycle pulse on final commit
overflow  out  1  sticky: accumulator wrapped during current run
ctrl_err  out  1  sticky: more than one sN_ctrl_in high in a cycle

Behaviour:
- Reset (reset=0, async): i, acc, data_reg, prod_reg, len_reg, base_reg, coef_reg, cond_reg, result=0. result_valid=0, overflow=0, ctrl_err=0, mem_rd_en=0.
- s0 & start: latch len_in, base_in and coef_in. Clear i, acc and overflow. start in any other state is ignored.
- s1: mem_rd_en=1 (combinational from s1_ctrl_in); mem_addr=base_reg+i, wrapping modulo 2^ADDR_W.
- s2: data_reg <= mem_rdata.
- s3: prod_reg <= data_reg*coef_reg (2*DATA_W bits, zero-extended to ACC_W).
- s4: acc <= acc+prod_reg modulo 2^ACC_W. If a carry out occurs, overflow <= 1.
- s5: i <= i+1; cond_reg <= ((i+1) < len_reg), compared at LEN_W+1 bits so i=2^LEN_W-1 does not wrap.
- s6: result <= acc. If cond_reg=0, result_valid pulses for exactly this cycle.
- B_ctrl_out0 = cond_reg (registered). It is stable from the cycle after s5 through s6, when the controller samples it.
- Do-while semantics: the body always runs at least once, so len_in=0 behaves as len_in=1.
- No active strobe (idle gaps): all registers hold.
- Multiple strobes high: act on the lowest-index active strobe only and set ctrl_err. ctrl_err clears only on reset.
- Reset mid-iteration: everything returns to reset values immediately. A following start begins a fresh run.
- overflow persists after result_valid until the next accepted start or reset.

Decomposition:
- Shared package fsm_loop_pkg: state index constants S0..S6 (bit positions of the one-hot vector), default widths, and a function for one-hot validity (popcount<=1).
- One natural sub-module, fsm_loop_mac: the s3 multiply register plus the s4 add/overflow register, with enables mul_en/acc_en/clr. It is reusable by sibling loop datapaths.
- Everything else (index counter, address adder, compare, result register) stays in the top.

Test Plan:
- Basic run: drive the strobe sequence as the controller does; len=3, base=0x10, coef=2, mem[0x10..0x12]=5,7,9 -> reads at 0x10, 0x11, 0x12; B_ctrl_out0=1,1,0 at the three s6 cycles; result=42 with result_valid high only in the third s6; overflow=0.
- Zero length: len=0, coef=1, mem[base]=0xABCD -> exactly one read; B_ctrl_out0=0 at first s6; result=0xABCD with valid pulse.
- Overflow/wrap: ACC_W=32 override, DATA_W=16, coef=0xFFFF, mem all 0xFFFF, len=2 -> result=0xFFFC0002 modulo 2^32, overflow=1 after the second s4; the next start clears overflow.
- Address wrap: base=0xFE, len=4 -> mem_addr sequence 0xFE, 0xFF, 0x00, 0x01.
- Async reset mid-run: assert reset=0 during s4 of iteration 2 -> all outputs 0 within the same cycle without waiting for a clock edge. A new run with len=1 then produces the correct single-product result.
- Control faults: s2 and s4 high together -> only the s2 action occurs and ctrl_err=1 sticky. start pulsed during s3 -> len_reg, base_reg and coef_reg are unchanged.

Source files
------------

// File: rtl/fsm_loop_pkg.sv
// Shared definitions for loop-controller datapaths: strobe bit positions, default widths
// and helpers for decoding the controller's one-hot state strobes.
package fsm_loop_pkg;

    localparam int S0         = 0;
    localparam int S1         = 1;
    localparam int S2         = 2;
    localparam int S3         = 3;
    localparam int S4         = 4;
    localparam int S5         = 5;
    localparam int S6         = 6;
    localparam int NUM_STATES = 7;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_LEN_W  = 8;
    localparam int DEF_ACC_W  = 40;

    typedef logic [NUM_STATES-1:0] strobe_t;

    function automatic logic onehot_ok(input strobe_t v);
        int n;
        n = 0;
        for (int k = 0; k < NUM_STATES; k++) begin
            n += int'(v[k]);
        end
        return (n <= 1);
    endfunction

    // Keeps only the lowest-index set bit so a faulty controller never fires two actions.
    function automatic strobe_t lowest_strobe(input strobe_t v);
        return v & (~v + strobe_t'(1));
    endfunction

endpackage

// File: rtl/fsm_loop_datapath_if.sv
// Synchronous-read memory port: the datapath is master, the memory is slave.
// Read data is expected one cycle after mem_rd_en.
interface fsm_loop_datapath_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) ();
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_rd_en, output mem_addr, input  mem_rdata);
    modport slave  (input  mem_rd_en, input  mem_addr, output mem_rdata);
endinterface

// File: rtl/fsm_loop_mac.sv
// Multiply register plus accumulate register with sticky carry-out detection.
// Latency: product 1 cycle after mul_en, sum 1 cycle after acc_en; no backpressure.
// clr zeroes the accumulator and overflow flag but leaves the product register alone.
module fsm_loop_mac #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              mul_en,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc,
    output logic              overflow
);
    logic [2*DATA_W-1:0] prod_reg;
    logic [ACC_W:0]      sum;

    assign sum = {1'b0, acc} + (ACC_W+1)'(prod_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_reg <= '0;
            acc      <= '0;
            overflow <= 1'b0;
        end else begin
            if (mul_en) begin
                prod_reg <= (2*DATA_W)'(a) * (2*DATA_W)'(b);
            end
            if (clr) begin
                acc      <= '0;
                overflow <= 1'b0;
            end else if (acc_en) begin
                acc <= sum[ACC_W-1:0];
                if (sum[ACC_W]) begin
                    overflow <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/fsm_loop_datapath.sv
// Loop datapath driven by a one-hot controller: per iteration read, multiply, accumulate.
// Latency: one strobe per stage; result and result_valid are presented during the final s6.
// No backpressure: the controller's strobes pace everything, idle cycles hold all state.
module fsm_loop_datapath
    import fsm_loop_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [LEN_W-1:0]    len_in,
    input  logic [ADDR_W-1:0]   base_in,
    input  logic [DATA_W-1:0]   coef_in,
    input  logic                s0_ctrl_in,
    input  logic                s1_ctrl_in,
    input  logic                s2_ctrl_in,
    input  logic                s3_ctrl_in,
    input  logic                s4_ctrl_in,
    input  logic                s5_ctrl_in,
    input  logic                s6_ctrl_in,
    fsm_loop_datapath_if.master mem,
    output logic                B_ctrl_out0,
    output logic [ACC_W-1:0]    result,
    output logic                result_valid,
    output logic                overflow,
    output logic                ctrl_err
);
    strobe_t           st;
    strobe_t           act;
    logic              accept;
    logic [LEN_W-1:0]  i;
    logic [LEN_W:0]    i_next;
    logic [LEN_W-1:0]  len_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [DATA_W-1:0] coef_reg;
    logic [DATA_W-1:0] data_reg;
    logic              cond_reg;
    logic [ACC_W-1:0]  result_reg;
    logic [ACC_W-1:0]  acc;

    assign st     = {s6_ctrl_in, s5_ctrl_in, s4_ctrl_in, s3_ctrl_in,
                     s2_ctrl_in, s1_ctrl_in, s0_ctrl_in};
    assign act    = lowest_strobe(st);
    assign accept = act[S0] & start;
    // One bit wider so the last index of a full-range trip count still compares correctly.
    assign i_next = {1'b0, i} + (LEN_W+1)'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i          <= '0;
            len_reg    <= '0;
            base_reg   <= '0;
            coef_reg   <= '0;
            data_reg   <= '0;
            cond_reg   <= 1'b0;
            result_reg <= '0;
            ctrl_err   <= 1'b0;
        end else begin
            if (!onehot_ok(st)) begin
                ctrl_err <= 1'b1;
            end
            if (accept) begin
                len_reg  <= len_in;
                base_reg <= base_in;
                coef_reg <= coef_in;
                i        <= '0;
            end
            if (act[S2]) begin
                data_reg <= mem.mem_rdata;
            end
            if (act[S5]) begin
                i        <= i_next[LEN_W-1:0];
                cond_reg <= (i_next < {1'b0, len_reg});
            end
            if (act[S6]) begin
                result_reg <= acc;
            end
        end
    end

    fsm_loop_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clr      (accept),
        .mul_en   (act[S3]),
        .acc_en   (act[S4]),
        .a        (data_reg),
        .b        (coef_reg),
        .acc      (acc),
        .overflow (overflow)
    );

    assign mem.mem_rd_en = act[S1] & reset;
    assign mem.mem_addr  = base_reg + ADDR_W'(i);
    assign B_ctrl_out0   = cond_reg;
    assign result_valid  = act[S6] & ~cond_reg & reset;
    // During s6 the committing value is forwarded so it lines up with the valid pulse.
    assign result        = act[S6] ? acc : result_reg;
endmodule

// File: tb/tb_fsm_loop_datapath.sv
module tb_fsm_loop_datapath;
    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  len_in;
    logic [7:0]  base_in;
    logic [15:0] coef_in;
    logic [6:0]  st;

    logic        b40, rv40, ovf40, err40;
    logic [39:0] res40;
    logic        b32, rv32, ovf32, err32;
    logic [31:0] res32;

    logic [15:0] mem [256];
    int          rd_cnt;
    int          checks;
    int          failures;

    logic [7:0]  a_o;
    logic        re_o, b_o, rv_o, ov_o;
    logic [39:0] r_o;
    logic [31:0] r32_o;
    int          rd_before;

    fsm_loop_datapath_if #(.ADDR_W(8), .DATA_W(16)) mif40 ();
    fsm_loop_datapath_if #(.ADDR_W(8), .DATA_W(16)) mif32 ();

    fsm_loop_datapath #(.DATA_W(16), .ADDR_W(8), .LEN_W(8), .ACC_W(40)) dut (
        .clk(clk), .reset(reset), .start(start), .len_in(len_in), .base_in(base_in),
        .coef_in(coef_in), .s0_ctrl_in(st[0]), .s1_ctrl_in(st[1]), .s2_ctrl_in(st[2]),
        .s3_ctrl_in(st[3]), .s4_ctrl_in(st[4]), .s5_ctrl_in(st[5]), .s6_ctrl_in(st[6]),
        .mem(mif40.master), .B_ctrl_out0(b40), .result(res40), .result_valid(rv40),
        .overflow(ovf40), .ctrl_err(err40)
    );

    fsm_loop_datapath #(.DATA_W(16), .ADDR_W(8), .LEN_W(8), .ACC_W(32)) dut32 (
        .clk(clk), .reset(reset), .start(start), .len_in(len_in), .base_in(base_in),
        .coef_in(coef_in), .s0_ctrl_in(st[0]), .s1_ctrl_in(st[1]), .s2_ctrl_in(st[2]),
        .s3_ctrl_in(st[3]), .s4_ctrl_in(st[4]), .s5_ctrl_in(st[5]), .s6_ctrl_in(st[6]),
        .mem(mif32.master), .B_ctrl_out0(b32), .result(res32), .result_valid(rv32),
        .overflow(ovf32), .ctrl_err(err32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mif40.mem_rd_en) mif40.mem_rdata <= mem[mif40.mem_addr];
        if (mif32.mem_rd_en) mif32.mem_rdata <= mem[mif32.mem_addr];
        if (mif40.mem_rd_en) rd_cnt <= rd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [6:0] v, input logic s);
        @(posedge clk);
        #1;
        st    = v;
        start = s;
        @(negedge clk);
    endtask

    task automatic do_start(input logic [7:0] l, input logic [7:0] b, input logic [15:0] c);
        len_in  = l;
        base_in = b;
        coef_in = c;
        cyc(7'h01, 1'b1);
    endtask

    // One loop body as the controller sequences it; samples s1 address and s6 outputs.
    task automatic iter(output logic [7:0] a, output logic re, output logic b,
                        output logic rv, output logic [39:0] r, output logic ov,
                        output logic [31:0] r32);
        cyc(7'h02, 1'b0);
        a  = mif40.mem_addr;
        re = mif40.mem_rd_en;
        cyc(7'h04, 1'b0);
        cyc(7'h08, 1'b0);
        cyc(7'h10, 1'b0);
        cyc(7'h20, 1'b0);
        cyc(7'h40, 1'b0);
        b   = b40;
        rv  = rv40;
        r   = res40;
        ov  = ovf32;
        r32 = res32;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rd_cnt   = 0;
        st       = '0;
        start    = 1'b0;
        len_in   = '0;
        base_in  = '0;
        coef_in  = '0;
        for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
        mem[8'h10] = 16'd5;
        mem[8'h11] = 16'd7;
        mem[8'h12] = 16'd9;
        mem[8'h20] = 16'hABCD;
        mem[8'h30] = 16'hFFFF;
        mem[8'h31] = 16'hFFFF;
        mem[8'hFE] = 16'd3;

        reset = 1'b1;
        #2 reset = 1'b0;
        #10;
        chk("rst_result", res40, 40'd0);
        chk("rst_valid", rv40, 1'b0);
        chk("rst_ovf", ovf40, 1'b0);
        chk("rst_err", err40, 1'b0);
        chk("rst_rd_en", mif40.mem_rd_en, 1'b0);
        chk("rst_cond", b40, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Basic run: 5*2 + 7*2 + 9*2 = 42
        do_start(8'd3, 8'h10, 16'd2);
        iter(a_o, re_o, b_o, rv_o, r_o, ov_o, r32_o);
        chk("basic_addr0", a_o, 8'h10);
        chk("basic_rden0", re_o, 1'b1);
        chk("basic_cond0", b_o, 1'b1);
        chk("basic_valid0", rv_o, 1'b0);
        iter(a_o, re_o, b_o, rv_o, r_o, ov_o, r32_o);
        chk("basic_addr1", a_o, 8'h11);
        chk("basic_cond1", b_o, 1'b1);
        chk("basic_valid1", rv_o, 1'b0);
        iter(a_o, re_o, b_o, rv_o, r_o, ov_o, r32_o);
        chk("basic_addr2", a_o, 8'h12);
        chk("basic_cond2", b_o, 1'b0);
        chk("basic_valid2", rv_o, 1'b1);
        chk("basic_result", r_o, 40'd42);
        cyc(7'h00, 1'b0);
        chk("basic_hold_result", res40, 40'd42);
        chk("basic_valid_gone", rv40, 1'b0);
        chk("basic_ovf", ovf40, 1'b0);
        chk("basic_err", err40, 1'b0);
        chk("idle_rden", mif40.mem_rd_en, 1'b0);

        // Zero length behaves as one iteration
        rd_before = rd_cnt;
        do_start(8'd0, 8'h20, 16'd1);
        iter(a_o, re_o, b_o, rv_o, r_o, ov_o, r32_o);
        chk("zero_cond", b_o, 1'b0);
        chk("zero_valid", rv_o, 1'b1);
        chk("zero_result", r_o, 40'h00_0000_ABCD);
        cyc(7'h00, 1'b0);
        chk("zero_reads", rd_cnt - rd_before, 1);

        // Overflow: 2 * 0xFFFE0001 = 0x1_FFFC_0002
        do_start(8'd2, 8'h30, 16'hFFFF);
        iter(a_o, re_o, b_o, rv_o, r_o, ov_o, r32_o);
        chk("ovf_after_iter0", ov_o, 1'b0);
        iter(a_o, re_o, b_o, rv_o, r_o, ov_o, r32_o);
        chk("ovf_after_iter1", ov_o, 1'b1);
        chk("ovf_result32", r32_o, 32'hFFFC_0002);
        chk("ovf_result40", r_o, 40'h01_FFFC_0002);
        chk("ovf_valid32", rv32, 1'b1);
        cyc(7'h00, 1'b0);
        chk("ovf_sticky", ovf32, 1'b1);
        chk("ovf_40_none", ovf40, 1'b0);

        // Address wrap; the accepted start also clears the overflow flag
        do_start(8'd4, 8'hFE, 16'd1);
        cyc(7'h00, 1'b0);
        chk("ovf_cleared", ovf32, 1'b0);
        iter(a_o, re_o, b_o, rv_o, r_o, ov_o, r32_o);
        chk("wrap_addr0", a_o, 8'hFE);
        iter(a_o, re_o, b_o, rv_o, r_o, ov_o, r32_o);
        chk("wrap_addr1", a_o, 8'hFF);
        iter(a_o, re_o, b_o, rv_o, r_o, ov_o, r32_o);
        chk("wrap_addr2", a_o, 8'h00);
        iter(a_o, re_o, b_o, rv_o, r_o, ov_o, r32_o);
        chk("wrap_addr3", a_o, 8'h01);
        chk("wrap_result", r_o, 40'd3);
        chk("wrap_valid", rv_o, 1'b1);

        // Async reset during s4 of the second iteration
        do_start(8'd3, 8'h10, 16'd2);
        iter(a_o, re_o, b_o, rv_o, r_o, ov_o, r32_o);
        cyc(7'h02, 1'b0);
        cyc(7'h04, 1'b0);
        cyc(7'h08, 1'b0);
        cyc(7'h10, 1'b0);
        chk("pre_rst_result", res40, 40'd10);
        chk("pre_rst_cond", b40, 1'b1);
        reset = 1'b0;
        #1;
        chk("mid_rst_result", res40, 40'd0);
        chk("mid_rst_cond", b40, 1'b0);
        chk("mid_rst_valid", rv40, 1'b0);
        chk("mid_rst_rden", mif40.mem_rd_en, 1'b0);
        st = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        do_start(8'd1, 8'h11, 16'd3);
        iter(a_o, re_o, b_o, rv_o, r_o, ov_o, r32_o);
        chk("post_rst_addr", a_o, 8'h11);
        chk("post_rst_cond", b_o, 1'b0);
        chk("post_rst_valid", rv_o, 1'b1);
        chk("post_rst_result", r_o, 40'd21);

        // Control faults: s2+s4 together, start pulsed during s3
        do_start(8'd1, 8'h12, 16'd1);
        cyc(7'h02, 1'b0);
        cyc(7'h14, 1'b0);
        len_in  = 8'd5;
        base_in = 8'h40;
        coef_in = 16'd7;
        cyc(7'h08, 1'b1);
        chk("fault_err_set", err40, 1'b1);
        cyc(7'h10, 1'b0);
        cyc(7'h20, 1'b0);
        cyc(7'h40, 1'b0);
        chk("fault_result", res40, 40'd9);
        chk("fault_cond", b40, 1'b0);
        chk("fault_valid", rv40, 1'b1);
        cyc(7'h02, 1'b0);
        chk("fault_base_kept", mif40.mem_addr, 8'h13);
        cyc(7'h00, 1'b0);
        chk("fault_err_sticky", err40, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
